// File: rtl/dmem_axil_rd_bridge_pkg.sv
// Shared definitions for the DMEM AXI4-Lite read bridge and its write-error sink.
//   - AXI response codes
//   - read FSM and write sink state encodings
package dmem_axil_rd_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE = 2'b00,
        RD_RD   = 2'b01,
        RD_CAP  = 2'b10,
        RD_RSP  = 2'b11
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/dmem_axil_rd_bridge_wr_err_sink.sv
// Write-error sink for read-only AXI4-Lite slaves.
// Accepts one AW and one W beat (either order, or the same cycle), discards them,
// and answers with a single SLVERR on B, held until bready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   awvalid/awready         write address handshake (address itself not needed)
//   wvalid/wready           write data handshake (data itself not needed)
//   bresp/bvalid/bready     write response, always SLVERR
module dmem_axil_rd_bridge_wr_err_sink
    import dmem_axil_rd_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       awvalid,
    output logic       awready,
    input  logic       wvalid,
    output logic       wready,
    output logic [1:0] bresp,
    output logic       bvalid,
    input  logic       bready
);

    // state  | meaning
    // W_IDLE | collecting AW and W; each ready drops once its beat is taken
    // W_RESP | both beats taken, bvalid held with SLVERR until bready

    wr_state_t wr_state;
    logic      aw_done;
    logic      w_done;
    logic      aw_got;
    logic      w_got;

    // Include the handshake happening this cycle so AW+W in the same cycle completes at once.
    assign aw_got = aw_done | (awvalid & awready);
    assign w_got  = w_done  | (wvalid  & wready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= AXI_RESP_OKAY;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_got && w_got) begin
                        wr_state <= W_RESP;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                        bresp    <= AXI_RESP_SLVERR;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end else begin
                        aw_done <= aw_got;
                        w_done  <= w_got;
                        awready <= ~aw_got;
                        wready  <= ~w_got;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state <= W_IDLE;
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmem_axil_rd_bridge.sv
// AXI4-Lite slave giving the interconnect read access to the RV32I data memory
// through its read-only side port. Writes are absorbed and answered with SLVERR.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   s_axil_ar*/s_axil_r*                AXI4-Lite read channels (one read outstanding)
//   s_axil_aw*/s_axil_w*/s_axil_b*      AXI4-Lite write channels (always SLVERR)
//   dmem_re_o, dmem_addr_o              DMEM side-port read request (byte offset, word aligned)
//   dmem_data_i                         DMEM side-port data, valid the cycle after dmem_re_o
module dmem_axil_rd_bridge
    import dmem_axil_rd_bridge_pkg::*;
#(
    parameter int          RV32I_DMEM_DEPTH = 4,
    parameter logic [31:0] DMEM_BASE        = 32'h0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    output logic        dmem_re_o,
    output logic [31:0] dmem_addr_o,
    input  logic [31:0] dmem_data_i
);

    // state   | meaning
    // RD_IDLE | arready high, waiting for an AR handshake
    // RD_RD   | dmem_re_o pulsed (unless out of range)
    // RD_CAP  | DMEM data valid, capture into rdata/rresp
    // RD_RSP  | rvalid held until rready

    localparam logic [31:0] DMEM_BYTES = 32'(RV32I_DMEM_DEPTH * 1024);

    rd_state_t   rd_state;
    logic [29:0] offset_q;
    logic        err_q;

    logic [32:0] ar_diff;
    logic [31:0] ar_offset;
    logic        ar_err;
    logic        ar_hs;
    logic        unused_bits;

    // Subtract in 33 bits so the borrow flags addresses below DMEM_BASE without wrapping.
    assign ar_diff   = {1'b0, s_axil_araddr} - {1'b0, DMEM_BASE};
    assign ar_offset = ar_diff[31:0];
    assign ar_err    = ar_diff[32] | (ar_offset >= DMEM_BYTES);
    assign ar_hs     = s_axil_arvalid & s_axil_arready;

    assign dmem_addr_o = {offset_q, 2'b00};

    // Write payloads and byte-lane address bits carry no meaning for this slave.
    assign unused_bits = ^{s_axil_awaddr, s_axil_wdata, ar_offset[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state       <= RD_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= 32'h0;
            s_axil_rresp   <= AXI_RESP_OKAY;
            dmem_re_o      <= 1'b0;
            offset_q       <= 30'h0;
            err_q          <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state       <= RD_RD;
                        s_axil_arready <= 1'b0;
                        offset_q       <= ar_offset[31:2];
                        err_q          <= ar_err;
                        dmem_re_o      <= ~ar_err;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                RD_RD: begin
                    rd_state  <= RD_CAP;
                    dmem_re_o <= 1'b0;
                end
                RD_CAP: begin
                    rd_state      <= RD_RSP;
                    s_axil_rdata  <= err_q ? 32'h0 : dmem_data_i;
                    s_axil_rresp  <= err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    s_axil_rvalid <= 1'b1;
                end
                RD_RSP: begin
                    if (s_axil_rready) begin
                        rd_state       <= RD_IDLE;
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    dmem_axil_rd_bridge_wr_err_sink u_wr_sink (
        .clk     (clk),
        .rst_n   (rst_n),
        .awvalid (s_axil_awvalid),
        .awready (s_axil_awready),
        .wvalid  (s_axil_wvalid),
        .wready  (s_axil_wready),
        .bresp   (s_axil_bresp),
        .bvalid  (s_axil_bvalid),
        .bready  (s_axil_bready)
    );

endmodule

// File: tb/tb_dmem_axil_rd_bridge.sv
module tb_dmem_axil_rd_bridge;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        dmem_re;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data;

    logic [31:0] mem [0:1023];
    int          re_count;
    int          errors;
    int          checks;

    dmem_axil_rd_bridge #(
        .RV32I_DMEM_DEPTH (4),
        .DMEM_BASE        (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .dmem_re_o      (dmem_re),
        .dmem_addr_o    (dmem_addr),
        .dmem_data_i    (dmem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM side-port model: 1-cycle registered read, read-only.
    always @(posedge clk) begin
        if (dmem_re) dmem_data <= mem[dmem_addr[11:2]];
    end

    always @(posedge clk) begin
        if (rst_n && dmem_re) re_count <= re_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        araddr  = 32'h0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = 32'h0;
        awvalid = 1'b0;
        wdata   = 32'h0;
        wvalid  = 1'b0;
        bready  = 1'b0;
    endtask

    task automatic wait_arready();
        for (int i = 0; i < 20 && arready !== 1'b1; i++) tick();
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL wait_arready: arready=%b after 20 cycles, required 1", arready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            araddr  = $urandom;
            arvalid = 1'($urandom);
            rready  = 1'($urandom);
            awaddr  = $urandom;
            awvalid = 1'($urandom);
            wdata   = $urandom;
            wvalid  = 1'($urandom);
            bready  = 1'($urandom);
            tick();
            checks++;
            if ({arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid, dmem_re, dmem_addr} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: arready=%b rdata=%h rresp=%b rvalid=%b awready=%b wready=%b bresp=%b bvalid=%b re=%b addr=%h, required all 0",
                         i, arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid, dmem_re, dmem_addr);
            end
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_arready_early: arready=%b, required 0", arready);
        end
        tick();
        checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: arready/awready/wready=%b, required 111", {arready, awready, wready});
        end
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input logic exp_re);
        int re0;
        wait_arready();
        re0 = re_count;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if (dmem_re !== exp_re || arready !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_rd[%h]: re=%b arready=%b rvalid=%b, required re=%b arready=0 rvalid=0",
                     addr, dmem_re, arready, rvalid, exp_re);
        end
        if (exp_re) begin
            checks++;
            if (dmem_addr !== ((addr - BASE) & 32'hFFFF_FFFC)) begin
                errors++;
                $display("FAIL read_addr[%h]: dmem_addr=%h, required %h", addr, dmem_addr,
                         (addr - BASE) & 32'hFFFF_FFFC);
            end
        end
        tick();
        checks++;
        if (dmem_re !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_cap[%h]: re=%b rvalid=%b, required 0 0", addr, dmem_re, rvalid);
        end
        tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp) begin
            errors++;
            $display("FAIL read_rsp[%h]: rvalid=%b rdata=%h rresp=%b, required 1 %h %b",
                     addr, rvalid, rdata, rresp, exp_data, exp_resp);
        end
        tick();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || (re_count - re0) !== int'(exp_re)) begin
            errors++;
            $display("FAIL read_done[%h]: rvalid=%b arready=%b re_pulses=%0d, required 0 1 %0d",
                     addr, rvalid, arready, re_count - re0, int'(exp_re));
        end
        rready = 1'b0;
    endtask

    task automatic test_read_stall();
        int re0;
        wait_arready();
        re0 = re_count;
        araddr  = BASE + 32'h8;
        arvalid = 1'b1;
        rready  = 1'b0;
        tick();
        araddr = BASE + 32'hC;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h0BAD_F00D || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 0badf00d 00 0",
                         i, rvalid, rdata, rresp, arready);
            end
            tick();
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || (re_count - re0) !== 1) begin
            errors++;
            $display("FAIL stall_release: rvalid=%b re_pulses=%0d, required 0 1", rvalid, re_count - re0);
        end
    endtask

    task automatic test_write_w_first();
        bready = 1'b0;
        wdata  = 32'h1234_5678;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_w_taken: wready=%b awready=%b bvalid=%b, required 0 1 0", wready, awready, bvalid);
        end
        tick();
        tick();
        awaddr  = BASE + 32'hC;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL write_b: bvalid=%b bresp=%b awready=%b wready=%b, required 1 10 0 0",
                     bvalid, bresp, awready, wready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) begin
                errors++;
                $display("FAIL write_b_hold[%0d]: bvalid=%b bresp=%b awready=%b, required 1 10 0",
                         i, bvalid, bresp, awready);
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL write_done: bvalid=%b awready=%b wready=%b, required 0 1 1", bvalid, awready, wready);
        end
        test_read(BASE + 32'hC, 32'hDEAD_BEEF, 2'b00, 1'b1);
    endtask

    task automatic test_concurrent_and_reset();
        int re0;
        wait_arready();
        araddr  = BASE + 32'h4;
        arvalid = 1'b1;
        rready  = 1'b1;
        awaddr  = BASE + 32'h4;
        awvalid = 1'b1;
        wdata   = 32'hFFFF_FFFF;
        wvalid  = 1'b1;
        bready  = 1'b1;
        tick();
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b10 || dmem_re !== 1'b1 || dmem_addr !== 32'h4) begin
            errors++;
            $display("FAIL concurrent_start: bvalid=%b bresp=%b re=%b addr=%h, required 1 10 1 00000004",
                     bvalid, bresp, dmem_re, dmem_addr);
        end
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL concurrent_b_done: bvalid=%b, required 0", bvalid);
        end
        tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h1111_2222 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL concurrent_r: rvalid=%b rdata=%h rresp=%b, required 1 11112222 00", rvalid, rdata, rresp);
        end
        tick();
        rready = 1'b0;
        bready = 1'b0;

        wait_arready();
        araddr  = BASE + 32'h10;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if (dmem_re !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd_state: re=%b, required 1", dmem_re);
        end
        re0   = re_count;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid, dmem_re, dmem_addr} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: arready=%b rvalid=%b awready=%b wready=%b bvalid=%b re=%b addr=%h, required all 0",
                     arready, rvalid, awready, wready, bvalid, dmem_re, dmem_addr);
        end
        tick();
        tick();
        checks++;
        if (re_count !== re0 || dmem_re !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_read: re_pulses=%0d re=%b rvalid=%b, required 0 0 0", re_count - re0, dmem_re, rvalid);
        end
        rst_n = 1'b1;
        tick();
        test_read(BASE + 32'h10, 32'hA500_0004, 2'b00, 1'b1);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        re_count = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[1] = 32'h1111_2222;
        mem[2] = 32'h0BAD_F00D;
        mem[3] = 32'hDEAD_BEEF;
        clear_inputs();
        rst_n = 1'b0;
        tick();

        test_reset();
        test_read(BASE + 32'hC, 32'hDEAD_BEEF, 2'b00, 1'b1);
        test_read(BASE + 32'hF, 32'hDEAD_BEEF, 2'b00, 1'b1);
        test_read(BASE + 32'h0FFC, 32'hA500_03FF, 2'b00, 1'b1);
        test_read(BASE + 32'h1000, 32'h0, 2'b10, 1'b0);
        test_read(32'h0FFF_FFFC, 32'h0, 2'b10, 1'b0);
        test_read(32'h0000_0000, 32'h0, 2'b10, 1'b0);
        test_read_stall();
        test_write_w_first();
        test_concurrent_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
